// File: rtl/spline_pkg.sv
// Shared constants, state encoding and sizing helper for spline consumers.
package spline_pkg;

  localparam int SAMPLES_PER_SEG = 10;
  localparam int SAMPLE_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int total_samples(input int n);
    return SAMPLES_PER_SEG * (n - 1);
  endfunction

endpackage

// File: rtl/spline_sample_mux.sv
// Selects one SAMPLE_W sample out of a packed spline vector; out-of-range indices yield zero.
module spline_sample_mux
  import spline_pkg::*;
#(
  parameter int NUM_SAMPLES = 50,
  parameter int IDX_W       = 6
) (
  input  logic [NUM_SAMPLES*SAMPLE_W-1:0] shadow,
  input  logic [IDX_W-1:0]                idx,
  output logic [SAMPLE_W-1:0]             sample
);

  // Sample selection
  always_comb begin
    sample = '0;
    if (int'(idx) < NUM_SAMPLES) begin
      sample = shadow[int'(idx)*SAMPLE_W +: SAMPLE_W];
    end else begin
      sample = '0;
    end
  end

endmodule

// File: rtl/spline_path_streamer.sv
// Drives the spline enable, snapshots its packed output and streams it one sample per beat.
module spline_path_streamer
  import spline_pkg::*;
#(
  parameter  int N             = 6,
  parameter  int SETTLE_CYCLES = 4,
  localparam int TOTAL         = total_samples(N),
  localparam int IDX_W         = $clog2(TOTAL),
  localparam int APPROX_W      = TOTAL * SAMPLE_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [APPROX_W-1:0] approximation,
  output logic                spline_enable,
  output logic [SAMPLE_W-1:0] point_data,
  output logic [IDX_W-1:0]    point_index,
  output logic                point_valid,
  input  logic                point_ready,
  output logic                point_last,
  output logic                busy,
  output logic                done
);

  state_e                state_q, state_d;
  logic [7:0]            settle_q, settle_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [APPROX_W-1:0]   shadow_q, shadow_d;
  logic                  spline_enable_q, spline_enable_d;
  logic [SAMPLE_W-1:0]   point_data_q, point_data_d;
  logic                  point_valid_q, point_valid_d;
  logic                  point_last_q, point_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SAMPLE_W-1:0]   sample_s;

  // Next state, settle countdown, snapshot and beat index
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    index_d  = index_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_SETTLE;
          settle_d = 8'(SETTLE_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          index_d = '0;
        end else if (settle_q == 8'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
          index_d = '0;
        end else begin
          shadow_d = approximation;
          index_d  = '0;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Abort wins over a coincident final handshake, so no done pulse follows
        if (abort) begin
          state_d = ST_IDLE;
          index_d = '0;
        end else if (point_valid_q && point_ready) begin
          if (point_last_q) begin
            state_d = ST_DONE;
            index_d = '0;
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        index_d = '0;
      end
    endcase
  end

  spline_sample_mux #(
    .NUM_SAMPLES (TOTAL),
    .IDX_W       (IDX_W)
  ) u_mux (
    .shadow (shadow_d),
    .idx    (index_d),
    .sample (sample_s)
  );

  // Registered outputs are derived from the upcoming state
  always_comb begin
    spline_enable_d = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
    point_valid_d   = (state_d == ST_STREAM);
    busy_d          = (state_d != ST_IDLE);
    done_d          = (state_d == ST_DONE);
    point_data_d    = '0;
    point_last_d    = 1'b0;
    if (state_d == ST_STREAM) begin
      point_data_d = sample_s;
      point_last_d = (index_d == IDX_W'(TOTAL - 1));
    end else begin
      point_data_d = '0;
      point_last_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      settle_q        <= 8'd0;
      index_q         <= '0;
      shadow_q        <= '0;
      spline_enable_q <= 1'b0;
      point_data_q    <= '0;
      point_valid_q   <= 1'b0;
      point_last_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      settle_q        <= settle_d;
      index_q         <= index_d;
      shadow_q        <= shadow_d;
      spline_enable_q <= spline_enable_d;
      point_data_q    <= point_data_d;
      point_valid_q   <= point_valid_d;
      point_last_q    <= point_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign spline_enable = spline_enable_q;
  assign point_data    = point_data_q;
  assign point_index   = index_q;
  assign point_valid   = point_valid_q;
  assign point_last    = point_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
